spi_register_bank: RTL and testbench
====================================

SPI_REGISTER_BANK -- requirements
Module: spi_register_bank

Interface
REQ-001 Parameter ADDR_W, 16, image buffer address width in bits.
REQ-002 Parameter METER_CH, 6, number of 8-bit metering bytes exposed.
REQ-003 Parameter PAN_W, 16, pan register width in bits; a multiple of 8, from 8 to 32.
REQ-004 Port clock_in, input, 1, system clock; all state updates on the falling edge.
REQ-005 Port reset_n_in, input, 1, reset: asynchronous, active-low.
REQ-006 Port opcode_in, input, 8, current SPI register address.
REQ-007 Port operand_in, input, 8, write byte.
REQ-008 Port operand_valid_in, input, 1, one-cycle pulse per written byte.
REQ-009 Port wr_operand_count_in, input, 32, index of the written byte within the transaction.
REQ-010 Port operand_read_in, input, 1, one-cycle pulse per byte shifted out.
REQ-011 Port rd_operand_count_in, input, 32, index of the byte being read.
REQ-012 Port response_out, output, 8, combinational read data.
REQ-013 Port start_capture_out, output, 1, one-cycle capture trigger.
REQ-014 Port capture_done_in, input, 1, one-cycle pulse from the image pipeline when the image is complete.
REQ-015 Port final_image_address_in, input, ADDR_W, last valid image address (total size minus 4).
REQ-016 Port image_data_in, input, 8, byte at image_address_out.
REQ-017 Port image_address_out, output, ADDR_W, image read pointer.
REQ-018 Port metering_in, input, 8*METER_CH, metering bytes; byte 0 in the LSBs.
REQ-019 Port compression_factor_out, output, 3, active quality setting.
REQ-020 Port zoom_out, output, 8, active zoom setting.
REQ-021 Port pan_out, output, PAN_W, active pan setting.
REQ-022 Port gamma_bypass_out, output, 1, active gamma bypass setting.
REQ-023 Port power_save_enable_out, output, 1, D-PHY power save enable.
REQ-024 Port busy_out, output, 1, high while the FSM is in CAPTURING.

Function
REQ-025 The capture FSM SHALL have three states: IDLE, CAPTURING and READY.
REQ-026 A START_CAPTURE write in IDLE or READY SHALL, in the same cycle: pulse start_capture_out (combinational), clear image_address_out, commit the shadow registers, and move the FSM to CAPTURING on the next edge.
REQ-027 A START_CAPTURE write in CAPTURING SHALL produce no pulse and SHALL set the sticky overrun flag.
REQ-028 capture_done_in in CAPTURING SHALL move the FSM to READY; capture_done_in in any other state SHALL be ignored.
REQ-029 capture_done_in coinciding with START_CAPTURE in CAPTURING SHALL move the FSM to READY, set overrun and produce no pulse.
REQ-030 QUALITY_FACTOR, ZOOM, PAN and GAMMA_BYPASS writes SHALL load shadow registers only; the outputs SHALL change only on a commit.
REQ-031 A PAN write SHALL be big-endian: byte index k loads bits [PAN_W-1-8k -: 8]; bytes with k >= PAN_W/8 SHALL be ignored.
REQ-032 A POWER_SAVE_ENABLE write SHALL update power_save_enable_out on the next edge, ignoring FSM state.
REQ-033 An operand_read_in with IMAGE_DATA SHALL increment image_address_out only in READY, and only while it is below total = final_image_address_in + 4; the pointer SHALL saturate at total.
REQ-034 If operand_read_in and a START_CAPTURE write coincide, the clear of image_address_out SHALL win.
REQ-035 BYTES_REMAINING SHALL return total - image_address_out in READY and 0 otherwise; read byte 0 is the MSB, following bytes step down, and indices past the last byte read the LSB.
REQ-036 IMAGE_DATA SHALL return image_data_in.
REQ-037 METERING SHALL return metering byte index min(rd_operand_count_in, METER_CH-1).
REQ-038 STATUS SHALL return {5'b0, overrun, ready, busy}; an operand_read_in on STATUS SHALL clear overrun on the next edge.
REQ-039 COMPRESSED_BYTES SHALL return final_image_address_in little-endian by rd index; indices past the last byte read 0.
REQ-040 Unknown opcodes SHALL read 0 and SHALL have no effect on writes.
REQ-041 All address arithmetic SHALL be ADDR_W bits wide and wrap modulo 2^ADDR_W.

Reset
REQ-042 Asserting reset SHALL asynchronously clear all outputs, all shadow registers and the overrun flag, and force the FSM to IDLE.
REQ-043 Reset asserted mid-capture SHALL return the FSM to IDLE with no start pulse; a later capture_done_in SHALL be ignored.

Structure
REQ-044 The opcode constants (START_CAPTURE 'h20, BYTES_REMAINING 'h21, IMAGE_DATA 'h22, ZOOM 'h23, PAN 'h24, METERING 'h25, QUALITY_FACTOR 'h26, POWER_SAVE_ENABLE 'h28, STATUS 'h30, COMPRESSED_BYTES 'h31, GAMMA_BYPASS 'h32) and the FSM state enum SHALL live in the shared package camera_regs_pkg.
REQ-045 The capture FSM and overrun flag SHALL be a sub-module named capture_sequencer.

Verification
REQ-046 Reset, then write QUALITY_FACTOR=5 -> compression_factor_out stays 0 until START_CAPTURE, then reads 5.
REQ-047 START_CAPTURE, capture_done_in, final address 'h0010 -> BYTES_REMAINING reads 'h00,'h14; 20 IMAGE_DATA reads take the pointer to 'h14; a 21st read leaves it at 'h14.
REQ-048 A second START_CAPTURE while busy -> no start pulse; STATUS reads 'h05, then 'h01 on the next read.
REQ-049 PAN writes 'hAB,'hCD,'hEF with PAN_W=16, then START_CAPTURE -> pan_out = 'hABCD.
REQ-050 METERING with METER_CH=6 at rd indices 0..7 -> returns bytes 0..5, then byte 5, byte 5.
REQ-051 Reset asserted during CAPTURING, then capture_done_in -> STATUS reads 'h00 and image_address_out = 0.

Source files
------------

// File: rtl/camera_regs_pkg.sv
// ----------------------------------------------------------------------------
// camera_regs_pkg: opcodes and capture state encoding shared by the register bank.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package camera_regs_pkg;

  localparam logic [7:0] OP_START_CAPTURE     = 8'h20;
  localparam logic [7:0] OP_BYTES_REMAINING   = 8'h21;
  localparam logic [7:0] OP_IMAGE_DATA        = 8'h22;
  localparam logic [7:0] OP_ZOOM              = 8'h23;
  localparam logic [7:0] OP_PAN               = 8'h24;
  localparam logic [7:0] OP_METERING          = 8'h25;
  localparam logic [7:0] OP_QUALITY_FACTOR    = 8'h26;
  localparam logic [7:0] OP_POWER_SAVE_ENABLE = 8'h28;
  localparam logic [7:0] OP_STATUS            = 8'h30;
  localparam logic [7:0] OP_COMPRESSED_BYTES  = 8'h31;
  localparam logic [7:0] OP_GAMMA_BYPASS      = 8'h32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CAPTURING = 2'd1,
    ST_READY     = 2'd2
  } capture_state_t;

endpackage

`default_nettype wire

// File: rtl/capture_sequencer.sv
// ----------------------------------------------------------------------------
// capture_sequencer: IDLE/CAPTURING/READY capture FSM with sticky overrun flag.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module capture_sequencer
  import camera_regs_pkg::*;
(
  input  logic clock_in,
  input  logic reset_n_in,
  input  logic start_req,
  input  logic capture_done,
  input  logic status_read,
  output logic start_pulse,
  output logic busy,
  output logic ready,
  output logic overrun
);

  capture_state_t state;

  // A start request is only honoured outside CAPTURING; otherwise it is an overrun.
  assign start_pulse = start_req && (state != ST_CAPTURING);

  always_ff @(negedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      ready   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (status_read) begin
        overrun <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            state <= ST_CAPTURING;
            busy  <= 1'b1;
            ready <= 1'b0;
          end
        end
        ST_CAPTURING: begin
          if (start_req) begin
            overrun <= 1'b1;
          end
          if (capture_done) begin
            state <= ST_READY;
            busy  <= 1'b0;
            ready <= 1'b1;
          end
        end
        ST_READY: begin
          if (start_req) begin
            state <= ST_CAPTURING;
            busy  <= 1'b1;
            ready <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_register_bank.sv
// ----------------------------------------------------------------------------
// spi_register_bank: SPI-addressed camera control registers and image readout.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_register_bank
  import camera_regs_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int METER_CH = 6,
  parameter int PAN_W    = 16
) (
  input  logic                  clock_in,
  input  logic                  reset_n_in,
  input  logic [7:0]            opcode_in,
  input  logic [7:0]            operand_in,
  input  logic                  operand_valid_in,
  input  logic [31:0]           wr_operand_count_in,
  input  logic                  operand_read_in,
  input  logic [31:0]           rd_operand_count_in,
  output logic [7:0]            response_out,
  output logic                  start_capture_out,
  input  logic                  capture_done_in,
  input  logic [ADDR_W-1:0]     final_image_address_in,
  input  logic [7:0]            image_data_in,
  output logic [ADDR_W-1:0]     image_address_out,
  input  logic [8*METER_CH-1:0] metering_in,
  output logic [2:0]            compression_factor_out,
  output logic [7:0]            zoom_out,
  output logic [PAN_W-1:0]      pan_out,
  output logic                  gamma_bypass_out,
  output logic                  power_save_enable_out,
  output logic                  busy_out
);

  localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
  localparam int PAN_BYTES  = PAN_W / 8;

  logic                    start_req;
  logic                    status_read;
  logic                    start_pulse;
  logic                    busy;
  logic                    ready;
  logic                    overrun;
  logic [ADDR_W-1:0]       total;
  logic [ADDR_W-1:0]       remaining;
  logic [8*ADDR_BYTES-1:0] remaining_pad;
  logic [8*ADDR_BYTES-1:0] final_pad;
  logic [2:0]              quality_shadow;
  logic [7:0]              zoom_shadow;
  logic [PAN_W-1:0]        pan_shadow;
  logic                    gamma_shadow;

  assign start_req   = operand_valid_in && (opcode_in == OP_START_CAPTURE);
  assign status_read = operand_read_in && (opcode_in == OP_STATUS);

  capture_sequencer u_capture_sequencer (
    .clock_in     (clock_in),
    .reset_n_in   (reset_n_in),
    .start_req    (start_req),
    .capture_done (capture_done_in),
    .status_read  (status_read),
    .start_pulse  (start_pulse),
    .busy         (busy),
    .ready        (ready),
    .overrun      (overrun)
  );

  assign start_capture_out = start_pulse;
  assign busy_out          = busy;

  // Final address points at the last 4-byte word, so the image is 4 bytes longer.
  assign total         = final_image_address_in + ADDR_W'(4);
  assign remaining     = ready ? (total - image_address_out) : '0;
  assign remaining_pad = (8*ADDR_BYTES)'(remaining);
  assign final_pad     = (8*ADDR_BYTES)'(final_image_address_in);

  always_ff @(negedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      quality_shadow <= '0;
      zoom_shadow    <= '0;
      pan_shadow     <= '0;
      gamma_shadow   <= 1'b0;
    end else if (operand_valid_in) begin
      case (opcode_in)
        OP_QUALITY_FACTOR: quality_shadow <= operand_in[2:0];
        OP_ZOOM:           zoom_shadow    <= operand_in;
        OP_GAMMA_BYPASS:   gamma_shadow   <= operand_in[0];
        OP_PAN: begin
          for (int b = 0; b < PAN_BYTES; b++) begin
            if (wr_operand_count_in == 32'(b)) begin
              pan_shadow[PAN_W-1-8*b -: 8] <= operand_in;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(negedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      compression_factor_out <= '0;
      zoom_out               <= '0;
      pan_out                <= '0;
      gamma_bypass_out       <= 1'b0;
      power_save_enable_out  <= 1'b0;
    end else begin
      if (start_pulse) begin
        compression_factor_out <= quality_shadow;
        zoom_out               <= zoom_shadow;
        pan_out                <= pan_shadow;
        gamma_bypass_out       <= gamma_shadow;
      end
      if (operand_valid_in && (opcode_in == OP_POWER_SAVE_ENABLE)) begin
        power_save_enable_out <= operand_in[0];
      end
    end
  end

  // Clearing on a new capture takes priority over any concurrent readout step.
  always_ff @(negedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      image_address_out <= '0;
    end else if (start_pulse) begin
      image_address_out <= '0;
    end else if (operand_read_in && (opcode_in == OP_IMAGE_DATA) && ready &&
                 (image_address_out < total)) begin
      image_address_out <= image_address_out + ADDR_W'(1);
    end
  end

  always_comb begin
    response_out = 8'h00;
    case (opcode_in)
      OP_BYTES_REMAINING: begin
        response_out = remaining_pad[7:0];
        for (int k = 0; k < ADDR_BYTES - 1; k++) begin
          if (rd_operand_count_in == 32'(k)) begin
            response_out = remaining_pad[8*(ADDR_BYTES-1-k) +: 8];
          end
        end
      end
      OP_IMAGE_DATA: response_out = image_data_in;
      OP_METERING: begin
        response_out = metering_in[8*(METER_CH-1) +: 8];
        for (int k = 0; k < METER_CH - 1; k++) begin
          if (rd_operand_count_in == 32'(k)) begin
            response_out = metering_in[8*k +: 8];
          end
        end
      end
      OP_STATUS: response_out = {5'b0, overrun, ready, busy};
      OP_COMPRESSED_BYTES: begin
        for (int k = 0; k < ADDR_BYTES; k++) begin
          if (rd_operand_count_in == 32'(k)) begin
            response_out = final_pad[8*k +: 8];
          end
        end
      end
      default: response_out = 8'h00;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_register_bank.sv
// ----------------------------------------------------------------------------
// tb_spi_register_bank: directed bench for the SPI camera register bank.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_spi_register_bank;

  localparam int ADDR_W   = 16;
  localparam int METER_CH = 6;
  localparam int PAN_W    = 16;

  logic                  clock_in = 1'b0;
  logic                  reset_n_in = 1'b0;
  logic [7:0]            opcode_in = 8'h00;
  logic [7:0]            operand_in = 8'h00;
  logic                  operand_valid_in = 1'b0;
  logic [31:0]           wr_operand_count_in = '0;
  logic                  operand_read_in = 1'b0;
  logic [31:0]           rd_operand_count_in = '0;
  logic [7:0]            response_out;
  logic                  start_capture_out;
  logic                  capture_done_in = 1'b0;
  logic [ADDR_W-1:0]     final_image_address_in = 16'h0010;
  logic [7:0]            image_data_in = 8'h5A;
  logic [ADDR_W-1:0]     image_address_out;
  logic [8*METER_CH-1:0] metering_in = 48'h66_55_44_33_22_11;
  logic [2:0]            compression_factor_out;
  logic [7:0]            zoom_out;
  logic [PAN_W-1:0]      pan_out;
  logic                  gamma_bypass_out;
  logic                  power_save_enable_out;
  logic                  busy_out;

  int checks = 0;
  int errors = 0;

  spi_register_bank #(
    .ADDR_W   (ADDR_W),
    .METER_CH (METER_CH),
    .PAN_W    (PAN_W)
  ) dut (
    .clock_in               (clock_in),
    .reset_n_in             (reset_n_in),
    .opcode_in              (opcode_in),
    .operand_in             (operand_in),
    .operand_valid_in       (operand_valid_in),
    .wr_operand_count_in    (wr_operand_count_in),
    .operand_read_in        (operand_read_in),
    .rd_operand_count_in    (rd_operand_count_in),
    .response_out           (response_out),
    .start_capture_out      (start_capture_out),
    .capture_done_in        (capture_done_in),
    .final_image_address_in (final_image_address_in),
    .image_data_in          (image_data_in),
    .image_address_out      (image_address_out),
    .metering_in            (metering_in),
    .compression_factor_out (compression_factor_out),
    .zoom_out               (zoom_out),
    .pan_out                (pan_out),
    .gamma_bypass_out       (gamma_bypass_out),
    .power_save_enable_out  (power_save_enable_out),
    .busy_out               (busy_out)
  );

  always #5 clock_in = ~clock_in;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Inputs change on the rising edge; the DUT updates on the falling edge.
  task automatic write_byte(input logic [7:0] op, input logic [7:0] data,
                            input int idx, output logic pulse);
    @(posedge clock_in);
    opcode_in           = op;
    operand_in          = data;
    wr_operand_count_in = idx;
    operand_valid_in    = 1'b1;
    #1 pulse = start_capture_out;
    @(posedge clock_in);
    operand_valid_in = 1'b0;
  endtask

  task automatic read_byte(input logic [7:0] op, input int idx, output logic [7:0] data);
    @(posedge clock_in);
    opcode_in           = op;
    rd_operand_count_in = idx;
    operand_read_in     = 1'b1;
    #1 data = response_out;
    @(posedge clock_in);
    operand_read_in = 1'b0;
  endtask

  task automatic pulse_done();
    @(posedge clock_in);
    capture_done_in = 1'b1;
    @(posedge clock_in);
    capture_done_in = 1'b0;
  endtask

  typedef struct {
    logic [7:0] op;
    int         idx;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic       p;
    logic [7:0] d;

    vecs[0]  = '{8'h25, 0, 8'h11, "meter0"};
    vecs[1]  = '{8'h25, 1, 8'h22, "meter1"};
    vecs[2]  = '{8'h25, 2, 8'h33, "meter2"};
    vecs[3]  = '{8'h25, 3, 8'h44, "meter3"};
    vecs[4]  = '{8'h25, 4, 8'h55, "meter4"};
    vecs[5]  = '{8'h25, 5, 8'h66, "meter5"};
    vecs[6]  = '{8'h25, 6, 8'h66, "meter6_clamp"};
    vecs[7]  = '{8'h25, 7, 8'h66, "meter7_clamp"};
    vecs[8]  = '{8'h31, 0, 8'h10, "compr0"};
    vecs[9]  = '{8'h31, 1, 8'h00, "compr1"};
    vecs[10] = '{8'h31, 2, 8'h00, "compr2_past"};
    vecs[11] = '{8'h22, 0, 8'h5A, "image_data"};
    vecs[12] = '{8'h27, 0, 8'h00, "unknown_op"};

    repeat (3) @(posedge clock_in);
    reset_n_in = 1'b1;
    @(posedge clock_in);

    chk("rst_compression", 32'(compression_factor_out), 0);
    chk("rst_pan", 32'(pan_out), 0);
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_addr", 32'(image_address_out), 0);
    chk("rst_pse", 32'(power_save_enable_out), 0);
    read_byte(8'h30, 0, d);
    chk("rst_status", 32'(d), 0);

    foreach (vecs[i]) begin
      @(posedge clock_in);
      opcode_in           = vecs[i].op;
      rd_operand_count_in = vecs[i].idx;
      #1 chk(vecs[i].name, 32'(response_out), 32'(vecs[i].exp));
    end

    // Shadow writes must not reach the outputs before a commit.
    write_byte(8'h26, 8'h05, 0, p);
    write_byte(8'h23, 8'h3C, 0, p);
    write_byte(8'h32, 8'h01, 0, p);
    write_byte(8'h24, 8'hAB, 0, p);
    write_byte(8'h24, 8'hCD, 1, p);
    write_byte(8'h24, 8'hEF, 2, p);
    chk("shadow_quality", 32'(compression_factor_out), 0);
    chk("shadow_zoom", 32'(zoom_out), 0);
    chk("shadow_pan", 32'(pan_out), 0);
    write_byte(8'h28, 8'h01, 0, p);
    chk("pse_set", 32'(power_save_enable_out), 1);

    write_byte(8'h20, 8'h00, 0, p);
    chk("start_pulse_idle", 32'(p), 1);
    chk("commit_quality", 32'(compression_factor_out), 5);
    chk("commit_zoom", 32'(zoom_out), 32'h3C);
    chk("commit_pan", 32'(pan_out), 32'hABCD);
    chk("commit_gamma", 32'(gamma_bypass_out), 1);
    chk("busy_capturing", 32'(busy_out), 1);
    read_byte(8'h21, 1, d);
    chk("remaining_not_ready", 32'(d), 0);
    read_byte(8'h22, 0, d);
    chk("addr_hold_capturing", 32'(image_address_out), 0);

    write_byte(8'h20, 8'h00, 0, p);
    chk("start_pulse_busy", 32'(p), 0);
    read_byte(8'h30, 0, d);
    chk("status_overrun", 32'(d), 32'h05);
    read_byte(8'h30, 0, d);
    chk("status_cleared", 32'(d), 32'h01);

    pulse_done();
    chk("busy_ready", 32'(busy_out), 0);
    read_byte(8'h30, 0, d);
    chk("status_ready", 32'(d), 32'h02);
    read_byte(8'h21, 0, d);
    chk("remaining_b0", 32'(d), 32'h00);
    read_byte(8'h21, 1, d);
    chk("remaining_b1", 32'(d), 32'h14);
    read_byte(8'h21, 2, d);
    chk("remaining_b2_lsb", 32'(d), 32'h14);
    for (int i = 0; i < 20; i++) read_byte(8'h22, i, d);
    chk("addr_after_20", 32'(image_address_out), 32'h14);
    read_byte(8'h22, 20, d);
    chk("addr_saturate", 32'(image_address_out), 32'h14);
    read_byte(8'h21, 1, d);
    chk("remaining_empty", 32'(d), 0);

    write_byte(8'h20, 8'h00, 0, p);
    chk("start_pulse_ready", 32'(p), 1);
    chk("addr_cleared", 32'(image_address_out), 0);
    chk("busy_restart", 32'(busy_out), 1);

    // Asynchronous reset in the middle of a capture.
    @(posedge clock_in);
    #2 reset_n_in = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy_out), 0);
    chk("async_rst_quality", 32'(compression_factor_out), 0);
    chk("async_rst_pse", 32'(power_save_enable_out), 0);
    @(posedge clock_in);
    reset_n_in = 1'b1;
    pulse_done();
    read_byte(8'h30, 0, d);
    chk("status_after_rst", 32'(d), 0);
    chk("addr_after_rst", 32'(image_address_out), 0);

    // Start and capture_done landing together while capturing.
    write_byte(8'h20, 8'h00, 0, p);
    chk("start_pulse_again", 32'(p), 1);
    @(posedge clock_in);
    opcode_in        = 8'h20;
    operand_valid_in = 1'b1;
    capture_done_in  = 1'b1;
    #1 chk("start_done_no_pulse", 32'(start_capture_out), 0);
    @(posedge clock_in);
    operand_valid_in = 1'b0;
    capture_done_in  = 1'b0;
    read_byte(8'h30, 0, d);
    chk("status_overrun_ready", 32'(d), 32'h06);

    // Total wraps modulo 2^ADDR_W.
    final_image_address_in = 16'hFFFE;
    read_byte(8'h21, 1, d);
    chk("wrap_remaining", 32'(d), 32'h02);
    for (int i = 0; i < 3; i++) read_byte(8'h22, i, d);
    chk("wrap_addr_saturate", 32'(image_address_out), 32'h02);
    read_byte(8'h31, 1, d);
    chk("compr_hi_byte", 32'(d), 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
